// File: rtl/twi_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the mirror register slave.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module twi_wb_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    output logic [1:0]              grant_o
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, BUS0, BUS1} state_t;

    state_t state_reg, state_next;
    logic   last_grant_reg, last_grant_next;
    logic   [1:0] grant;
    logic   stb_raw;
    logic   timeout;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // A grant is released only when its owner drops cyc; the waiting
    // master takes over on the same edge so there is no idle bubble.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_next = last_grant_reg ? BUS0 : BUS1;
                else if (m0_cyc_i)
                    state_next = BUS0;
                else if (m1_cyc_i)
                    state_next = BUS1;
            end
            BUS0: begin
                if (!m0_cyc_i) begin
                    last_grant_next = 1'b0;
                    state_next      = m1_cyc_i ? BUS1 : IDLE;
                end
            end
            BUS1: begin
                if (!m1_cyc_i) begin
                    last_grant_next = 1'b1;
                    state_next      = m0_cyc_i ? BUS0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant   = {state_reg == BUS1, state_reg == BUS0};
    assign grant_o = grant;

    assign s_cyc_o = (grant[0] & m0_cyc_i) | (grant[1] & m1_cyc_i);
    assign stb_raw = (grant[0] & m0_stb_i) | (grant[1] & m1_stb_i);
    assign s_stb_o = stb_raw & ~timeout;
    assign s_we_o  = (grant[0] & m0_we_i) | (grant[1] & m1_we_i);
    assign s_adr_o = ({ADDR_WIDTH{grant[0]}} & m0_adr_i) | ({ADDR_WIDTH{grant[1]}} & m1_adr_i);
    assign s_dat_o = ({DATA_WIDTH{grant[0]}} & m0_dat_i) | ({DATA_WIDTH{grant[1]}} & m1_dat_i);
    assign s_sel_o = ({SEL_WIDTH{grant[0]}} & m0_sel_i) | ({SEL_WIDTH{grant[1]}} & m1_sel_i);

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = grant[0] & s_ack_i;
    assign m1_ack_o = grant[1] & s_ack_i;
    assign m0_err_o = grant[0] & (s_err_i | timeout);
    assign m1_err_o = grant[1] & (s_err_i | timeout);

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] WDT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wdt_reg, wdt_next;
    logic        stalled;

    assign stalled = s_cyc_o & stb_raw & ~s_ack_i & ~s_err_i;
    assign timeout = stalled & (wdt_reg == WDT_LAST);

    // The hung strobe is withheld for the err cycle; the grant stays put.
    always_comb begin
        wdt_next = wdt_reg + 16'd1;
        if (!stalled || timeout || (state_next != state_reg))
            wdt_next = 16'd0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            wdt_reg <= 16'd0;
        else
            wdt_reg <= wdt_next;
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
